// File: rtl/hack_pkg.sv
// ============================================================================
// hack_pkg : shared Hack memory-map constants, arbiter state and owner types
// Revision : 1.0
// ============================================================================
`default_nettype none

package hack_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;
    localparam logic [14:0] RAM_TOP     = 15'h3FFF;

    // Screen-relative word offset to absolute address; carry out is dropped.
    function automatic logic [14:0] screen_abs(input logic [14:0] base,
                                               input logic [12:0] offset);
        return base + {2'b00, offset};
    endfunction

endpackage

`default_nettype wire

// File: rtl/hack_mem_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin grant, bit 0 = CPU, bit 1 = video
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import hack_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // On a tie the side not served last wins.
            2'b11:   grant_o = (last_grant_i == OWN_CPU) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hack_mem_arbiter.sv
// ============================================================================
// hack_mem_arbiter : shares the Hack data-memory port between CPU and video
// Revision : 1.0
// ============================================================================
`default_nettype none

module hack_mem_arbiter #(
    parameter logic [14:0] SCREEN_BASE = hack_pkg::SCREEN_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic [15:0] vid_rdata,
    output logic        vid_ack,
    output logic [14:0] mem_address,
    output logic [15:0] mem_in,
    output logic        mem_load,
    input  logic [15:0] mem_out
);
    import hack_pkg::*;

    arb_state_t  state_q;
    owner_t      owner_q;
    owner_t      last_grant_q;
    logic        we_q;
    logic [14:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] vid_rdata_q;
    logic        cpu_ack_q;
    logic        vid_ack_q;

    logic [1:0]  grant;
    logic [14:0] vid_abs_addr;

    assign vid_abs_addr = screen_abs(SCREEN_BASE, vid_addr);

    rr_arb2 u_rr_arb2 (
        .req_i        ({vid_req, cpu_req}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            vid_ack_q    <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant[1]) begin
                        owner_q <= OWN_VID;
                        we_q    <= 1'b0;
                        addr_q  <= vid_abs_addr;
                        wdata_q <= '0;
                        state_q <= ARB_ADDR;
                    end else if (grant[0]) begin
                        owner_q <= OWN_CPU;
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        state_q <= ARB_ADDR;
                    end
                end
                ARB_ADDR: state_q <= ARB_DATA;
                ARB_DATA: begin
                    if (owner_q == OWN_VID) begin
                        vid_rdata_q <= mem_out;
                        vid_ack_q   <= 1'b1;
                    end else begin
                        cpu_rdata_q <= mem_out;
                        cpu_ack_q   <= 1'b1;
                    end
                    last_grant_q <= owner_q;
                    state_q      <= ARB_RESP;
                end
                ARB_RESP: begin
                    cpu_ack_q <= 1'b0;
                    vid_ack_q <= 1'b0;
                    state_q   <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Memory side is decoded from state so reset drops mem_load immediately.
    always_comb begin
        mem_address = '0;
        mem_in      = '0;
        mem_load    = 1'b0;
        if (state_q == ARB_ADDR || state_q == ARB_DATA) begin
            mem_address = addr_q;
            mem_in      = wdata_q;
        end
        if (state_q == ARB_ADDR) begin
            mem_load = we_q;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign vid_ack   = vid_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_hack_mem_arbiter.sv
// ============================================================================
// tb_hack_mem_arbiter : directed corner cases plus randomized scoreboard run
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hack_mem_arbiter;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cpu_req   = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [14:0] cpu_addr  = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        vid_req   = 1'b0;
    logic [12:0] vid_addr  = '0;
    logic [15:0] vid_rdata;
    logic        vid_ack;
    logic [14:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out   = '0;

    int n_checks = 0;
    int n_pass   = 0;
    bit sb_en    = 1'b0;

    always #5 clk = ~clk;

    hack_mem_arbiter #(.SCREEN_BASE(15'h4000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_rdata   (vid_rdata),
        .vid_ack     (vid_ack),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load),
        .mem_out     (mem_out)
    );

    // Power-on contents of every word, known to both memory and model.
    function automatic logic [15:0] pattern(input logic [14:0] a);
        logic [31:0] p;
        p = {17'd0, a} * 32'h0000_9E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    // Memory block: registered read, writes above the screen are ignored.
    bit [15:0] mem_data [0:32767];
    bit        mem_wr   [0:32767];
    always @(posedge clk) begin
        mem_out <= mem_wr[mem_address] ? mem_data[mem_address] : pattern(mem_address);
        if (mem_load && mem_address < 15'h6000) begin
            mem_data[mem_address] <= mem_in;
            mem_wr[mem_address]   <= 1'b1;
        end
    end

    // Reference model: what a word should read as, from writes issued so far.
    logic [15:0] shadow [int];
    function automatic logic [15:0] model_read(input logic [14:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return pattern(a);
    endfunction
    function automatic void model_write(input logic [14:0] a, input logic [15:0] d);
        if (a < 15'h6000) shadow[int'(a)] = d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val >= lo && val <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    endtask

    typedef struct packed {
        logic        is_read;
        logic [15:0] data;
    } exp_t;

    exp_t        cpu_q [$];
    logic [15:0] vid_q [$];
    exp_t        mon_e;
    logic [15:0] mon_v;

    always @(negedge clk) begin
        if (sb_en && (cpu_ack || vid_ack)) begin
            check("ack_exclusive", 32'(cpu_ack & vid_ack), 32'd0);
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_ack", 32'(cpu_ack), 32'd0);
                end else begin
                    mon_e = cpu_q.pop_front();
                    if (mon_e.is_read) check("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.data));
                end
            end
            if (vid_ack) begin
                if (vid_q.size() == 0) begin
                    check("vid_unexpected_ack", 32'(vid_ack), 32'd0);
                end else begin
                    mon_v = vid_q.pop_front();
                    check("vid_rdata", 32'(vid_rdata), 32'(mon_v));
                end
            end
        end
    end

    task automatic cpu_op(input bit we, input logic [14:0] a, input logic [15:0] d);
        int   cyc;
        exp_t e;
        @(negedge clk);
        e.is_read = !we;
        e.data    = model_read(a);
        if (we) model_write(a, d);
        cpu_q.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!cpu_ack && cyc < 20);
        cpu_req = 1'b0;
        check_range("cpu_latency", cyc, 3, 7);
    endtask

    task automatic vid_op(input logic [12:0] off);
        int cyc;
        @(negedge clk);
        vid_q.push_back(model_read(15'h4000 + {2'b00, off}));
        vid_req = 1'b1; vid_addr = off;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!vid_ack && cyc < 20);
        vid_req = 1'b0;
        check_range("vid_latency", cyc, 3, 7);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] vmask, cmask;
        int          overlap, ack_seen;

        // Reset with both sides requesting.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
        vid_req = 1'b1; vid_addr = 13'h0123;
        repeat (2) @(negedge clk);
        check("rst_cpu_ack",   32'(cpu_ack),     32'd0);
        check("rst_vid_ack",   32'(vid_ack),     32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata),   32'd0);
        check("rst_vid_rdata", 32'(vid_rdata),   32'd0);
        check("rst_mem_addr",  32'(mem_address), 32'd0);
        check("rst_mem_in",    32'(mem_in),      32'd0);
        check("rst_mem_load",  32'(mem_load),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant_vid_addr", 32'(mem_address), 32'h4123);
        check("first_grant_no_load",  32'(mem_load),    32'd0);
        repeat (2) @(negedge clk);
        check("first_vid_ack",   32'(vid_ack),   32'd1);
        check("first_vid_rdata", 32'(vid_rdata), 32'(pattern(15'h4123)));
        check("first_no_cpu",    32'(cpu_ack),   32'd0);
        vid_req = 1'b0;
        repeat (4) @(negedge clk);
        check("second_cpu_ack",   32'(cpu_ack),   32'd1);
        check("second_cpu_rdata", 32'(cpu_rdata), 32'(pattern(15'h0005)));
        cpu_req = 1'b0;

        // CPU write then read-back.
        @(negedge clk);
        model_write(15'h0010, 16'hBEEF);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        check("wr_addr_load", 32'(mem_load),    32'd1);
        check("wr_addr_addr", 32'(mem_address), 32'h0010);
        check("wr_addr_data", 32'(mem_in),      32'hBEEF);
        @(negedge clk);
        check("wr_data_noload", 32'(mem_load), 32'd0);
        @(negedge clk);
        check("wr_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rd_ack",   32'(cpu_ack),   32'd1);
        check("rd_rdata", 32'(cpu_rdata), 32'hBEEF);
        cpu_req = 1'b0;

        // Contention: both held for 16 cycles.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020;
        vid_req = 1'b1; vid_addr = 13'h0040;
        vmask = '0; cmask = '0; overlap = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            vmask[k] = vid_ack;
            cmask[k] = cpu_ack;
            if (vid_ack && cpu_ack) overlap++;
            if (vid_ack) check("cont_vid_rdata", 32'(vid_rdata), 32'(pattern(15'h4040)));
            if (cpu_ack) check("cont_cpu_rdata", 32'(cpu_rdata), 32'(pattern(15'h0020)));
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        check("cont_vid_ack_cycles", 32'(vmask), 32'h0808);
        check("cont_cpu_ack_cycles", 32'(cmask), 32'h8080);
        check("cont_overlap",        32'(overlap), 32'd0);

        // Video rebasing at the top of the screen window.
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 13'h1FFF;
        @(negedge clk);
        check("rebase_addr",   32'(mem_address), 32'h5FFF);
        check("rebase_load_a", 32'(mem_load),    32'd0);
        @(negedge clk);
        check("rebase_load_d", 32'(mem_load),    32'd0);
        @(negedge clk);
        check("rebase_ack",   32'(vid_ack),   32'd1);
        check("rebase_rdata", 32'(vid_rdata), 32'(pattern(15'h5FFF)));
        vid_req = 1'b0;

        // Request held through its ack is re-granted from IDLE.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        repeat (3) @(negedge clk);
        check("held_ack1", 32'(cpu_ack), 32'd1);
        @(negedge clk);
        check("held_idle_noack", 32'(cpu_ack),     32'd0);
        check("held_idle_addr",  32'(mem_address), 32'd0);
        @(negedge clk);
        check("held_regrant_addr", 32'(mem_address), 32'h0010);
        repeat (2) @(negedge clk);
        check("held_ack2",   32'(cpu_ack),   32'd1);
        check("held_rdata2", 32'(cpu_rdata), 32'hBEEF);
        cpu_req = 1'b0;

        // Reset during ADDR of a write abandons it.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0030; cpu_wdata = 16'h1234;
        @(negedge clk);
        check("midrst_load_before", 32'(mem_load), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_load_drop", 32'(mem_load),    32'd0);
        check("midrst_addr_drop", 32'(mem_address), 32'd0);
        cpu_req = 1'b0;
        ack_seen = 0;
        repeat (2) @(negedge clk) if (cpu_ack) ack_seen++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk) if (cpu_ack) ack_seen++;
        check("midrst_no_ack",    32'(ack_seen),    32'd0);
        check("midrst_idle_addr", 32'(mem_address), 32'd0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0030;
        repeat (3) @(negedge clk);
        check("midrst_readback_ack",   32'(cpu_ack),   32'd1);
        check("midrst_readback_rdata", 32'(cpu_rdata), 32'(model_read(15'h0030)));
        cpu_req = 1'b0;

        // Randomized traffic on both ports, checked by the scoreboard.
        @(negedge clk);
        sb_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    int          r;
                    logic [14:0] a;
                    r = int'($urandom_range(0, 9));
                    if (r < 6)       a = 15'($urandom_range(0, 15));
                    else if (r < 8)  a = 15'h6000 + 15'($urandom_range(0, 7));
                    else             a = 15'h4000 + 15'($urandom_range(0, 8191));
                    if (a >= 15'h4000 && a < 15'h6000)
                        cpu_op(1'b0, a, 16'h0);
                    else
                        cpu_op(1'($urandom_range(0, 1)), a, 16'($urandom));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    vid_op(13'($urandom_range(0, 8191)));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join
        repeat (4) @(negedge clk);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("vid_q_drained", 32'(vid_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hack_mem_arbiter.md
# hack_mem_arbiter

Two-port arbiter that shares the single Hack data-memory port (15-bit address, 16-bit data, RAM/screen/keyboard map) between the CPU and a read-only video scan-out engine. It sits directly in front of the memory block. It sequences each access through a fixed address/data/response state machine and resolves contention with two-way round-robin. Video addresses are screen-relative and are rebased onto the screen window by this block.

## Interface
Parameters:
- SCREEN_BASE, 15'h4000, absolute base added to video word offsets

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU request; held with payload stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  15  absolute Hack address
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video read request; held with address until vid_ack
- vid_addr  in  13  screen word offset 0..8191
- vid_rdata  out  16  read data, valid while vid_ack=1
- vid_ack  out  1  one-cycle completion pulse
- mem_address  out  15  to memory address
- mem_in  out  16  to memory write data
- mem_load  out  1  to memory write enable
- mem_out  in  16  from memory; valid in the cycle after mem_address is presented

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the requester not granted last (last_grant register).
  - On grant, latch owner, we, address and wdata; go to ADDR.
  - Video address latches as SCREEN_BASE + vid_addr, 15-bit add, no carry out. Video we is forced to 0.
- ADDR: drive mem_address and mem_in from the latch. mem_load = latched we for this cycle only. Go to DATA.
- DATA:
  - Hold mem_address, mem_load=0.
  - At the edge, capture mem_out into the owner's rdata register and set the owner's ack.
  - Update last_grant to the owner.
  - Go to RESP.
- RESP: owner's ack=1 for exactly this cycle. Both req inputs are ignored this cycle. Always go to IDLE.
- Writes also return ack. Write rdata reflects mem_out during DATA and is don't-care to the requester.
- The non-owner's rdata holds its last value. The non-owner's ack stays 0.
- No address range checking. A CPU write at or above 15'h6000 is forwarded; the memory ignores it.
- Reset (async, any state):
  - state=IDLE, last_grant=CPU so video wins the first tie.
  - Latches cleared.
  - All outputs 0, including mem_load. An in-flight access is abandoned with no ack.

## Timing
- Request sampled in IDLE at edge 0. ADDR in cycle 1. DATA in cycle 2. ack and rdata in cycle 3.
- Request-to-ack latency is 3 cycles. Back-to-back throughput is one access per 4 cycles.
- Both requesters pending continuously: grants alternate, each sees an ack every 8 cycles. Maximum wait is 7 cycles after the competitor is granted.
- A requester sampling req=1 in the cycle after its ack is a new request.
- Outputs are registered except mem_address, mem_in and mem_load, which are decoded from state and latch with no input path.

## Structure
- Shared package hack_pkg holds:
  - State enum ARB_IDLE/ARB_ADDR/ARB_DATA/ARB_RESP.
  - Owner encoding OWN_CPU/OWN_VID.
  - Map constants SCREEN_BASE=15'h4000, KBD_ADDR=15'h6000, RAM_TOP=15'h3FFF, reused by the memory decode.
- One sub-module, rr_arb2: two request bits in, last_grant in, one-hot grant out, purely combinational. It is instantiated in IDLE decode.

## Test plan
- Reset: hold rst_n=0 with both req=1. All outputs 0, no ack. Release. Video is granted first: mem_address=15'h4000+vid_addr in cycle 1, vid_ack in cycle 3.
- CPU write then read: write 16'hBEEF to 15'h0010, ack at cycle 3 with mem_load high only in ADDR. Then read 15'h0010: cpu_rdata=16'hBEEF with cpu_ack.
- Video rebasing: vid_addr=13'h1FFF. mem_address=15'h5FFF, mem_load=0 throughout.
- Contention: both req held for 16 cycles. Acks are vid, cpu, vid, cpu at cycles 3, 7, 11, 15. No ack overlaps.
- Req held through ack: cpu_req stays high after its ack. RESP ignores it. Re-grant happens from IDLE, next ack 4 cycles later.
- Reset mid-write: drop rst_n during ADDR of a CPU write. mem_load falls immediately, no cpu_ack, state IDLE after release.
